// File: rtl/cla_adder_pipe.sv
// Pipelined carry-lookahead adder/subtractor with valid/ready on both sides.
// An input register is followed by one lookahead group per stage, so latency is WIDTH/BLOCK cycles.
module cla_adder_pipe #(
  parameter int WIDTH = 16,
  parameter int BLOCK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);
  localparam int NBLK = WIDTH / BLOCK;

  if (WIDTH % BLOCK != 0) begin : g_bad_width
    $error("cla_adder_pipe: WIDTH must be a multiple of BLOCK");
  end

  logic en;

  // Per-boundary view of the pipeline; index k feeds stage k.
  logic             valid_pipe [0:NBLK];
  logic [WIDTH-1:0] a_pipe     [0:NBLK-1];
  logic [WIDTH-1:0] b_pipe     [0:NBLK-1];
  logic [WIDTH-1:0] sum_pipe   [0:NBLK];
  logic             carry_pipe [0:NBLK];
  logic             cmsb_last;

  logic             valid_in_reg;
  logic [WIDTH-1:0] a_in_reg;
  logic [WIDTH-1:0] b_in_reg;
  logic             c_in_reg;

  assign en       = ~out_valid | out_ready;
  assign in_ready = en;

  // Capture stage: subtraction becomes a + ~b + 1 here.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_in_reg <= 1'b0;
      a_in_reg     <= '0;
      b_in_reg     <= '0;
      c_in_reg     <= 1'b0;
    end else if (en) begin
      valid_in_reg <= in_valid;
      a_in_reg     <= a;
      b_in_reg     <= b ^ {WIDTH{sub}};
      c_in_reg     <= sub | cin;
    end
  end

  assign valid_pipe[0] = valid_in_reg;
  assign a_pipe[0]     = a_in_reg;
  assign b_pipe[0]     = b_in_reg;
  assign sum_pipe[0]   = '0;
  assign carry_pipe[0] = c_in_reg;

  for (genvar gi = 0; gi < NBLK; gi++) begin : g_stage
    logic [BLOCK-1:0] p;
    logic [BLOCK-1:0] g;
    logic [BLOCK-1:0] s;
    logic [BLOCK:0]   cy;
    logic             term;
    logic [WIDTH-1:0] sum_next;
    logic             valid_reg;
    logic [WIDTH-1:0] sum_reg;
    logic             carry_reg;

    assign p = a_pipe[gi][gi*BLOCK +: BLOCK] ^ b_pipe[gi][gi*BLOCK +: BLOCK];
    assign g = a_pipe[gi][gi*BLOCK +: BLOCK] & b_pipe[gi][gi*BLOCK +: BLOCK];

    // Each carry is an independent sum of products of g, p and the group carry-in.
    always_comb begin
      cy    = '0;
      term  = 1'b0;
      cy[0] = carry_pipe[gi];
      for (int i = 0; i < BLOCK; i++) begin
        term = carry_pipe[gi];
        for (int k = 0; k <= i; k++) term = term & p[k];
        cy[i+1] = term;
        for (int j = 0; j <= i; j++) begin
          term = g[j];
          for (int k = j + 1; k <= i; k++) term = term & p[k];
          cy[i+1] = cy[i+1] | term;
        end
      end
    end

    assign s = p ^ cy[BLOCK-1:0];

    always_comb begin
      sum_next = sum_pipe[gi];
      sum_next[gi*BLOCK +: BLOCK] = s;
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        valid_reg <= 1'b0;
        sum_reg   <= '0;
        carry_reg <= 1'b0;
      end else if (en) begin
        valid_reg <= valid_pipe[gi];
        sum_reg   <= sum_next;
        carry_reg <= cy[BLOCK];
      end
    end

    assign valid_pipe[gi+1] = valid_reg;
    assign sum_pipe[gi+1]   = sum_reg;
    assign carry_pipe[gi+1] = carry_reg;

    if (gi < NBLK - 1) begin : g_fwd
      logic [WIDTH-1:0] a_reg;
      logic [WIDTH-1:0] b_reg;
      always_ff @(posedge clk) begin
        if (rst) begin
          a_reg <= '0;
          b_reg <= '0;
        end else if (en) begin
          a_reg <= a_pipe[gi];
          b_reg <= b_pipe[gi];
        end
      end
      assign a_pipe[gi+1] = a_reg;
      assign b_pipe[gi+1] = b_reg;
    end else begin : g_msb
      // Carry into the word MSB, kept for the overflow flag.
      logic cmsb_reg;
      always_ff @(posedge clk) begin
        if (rst) begin
          cmsb_reg <= 1'b0;
        end else if (en) begin
          cmsb_reg <= cy[BLOCK-1];
        end
      end
      assign cmsb_last = cmsb_reg;
    end
  end

  assign out_valid = valid_pipe[NBLK];
  assign sum       = sum_pipe[NBLK];
  assign cout      = carry_pipe[NBLK];
  assign ovf       = carry_pipe[NBLK] ^ cmsb_last;

endmodule

// File: tb/tb_cla_adder_pipe.sv
// Scoreboard bench for cla_adder_pipe: directed cases, stall, mid-flight reset, random traffic.
module tb_cla_adder_pipe;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic        cin = 1'b0;
  logic        sub = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] sum;
  logic        cout;
  logic        ovf;

  int total = 0;
  int bad = 0;
  int n_out = 0;
  logic [17:0] exp_q[$];
  logic        holding = 1'b0;
  logic [17:0] held;
  bit          saw_ir_low = 0;
  bit          rand_done = 0;

  cla_adder_pipe #(.WIDTH(16), .BLOCK(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf)
  );

  always #5 clk = ~clk;

  // Reference: plain integer arithmetic on unsigned and signed views.
  function automatic logic [17:0] model(input logic [15:0] ma, input logic [15:0] mb,
                                        input logic mcin, input logic msub);
    int ua, ub, ures, sa, sb, sres;
    logic [15:0] s;
    logic co, ov;
    ua = int'(ma);
    ub = int'(mb);
    sa = int'($signed(ma));
    sb = int'($signed(mb));
    if (msub) begin
      ures = ua - ub;
      sres = sa - sb;
      co   = (ua >= ub);
    end else begin
      ures = ua + ub + int'(mcin);
      sres = sa + sb + int'(mcin);
      co   = (ures > 65535);
    end
    s  = ures[15:0];
    ov = (sres > 32767) || (sres < -32768);
    return {ov, co, s};
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%h want=%h", name, got, want);
    end
  endtask

  task automatic send(input logic [15:0] ta, input logic [15:0] tb, input logic tcin, input logic tsub);
    bit acc = 0;
    a = ta; b = tb; cin = tcin; sub = tsub; in_valid = 1'b1;
    for (int n = 0; n < 200 && !acc; n++) begin
      @(negedge clk);
      acc = in_ready && !rst;
      @(posedge clk);
      if (acc) exp_q.push_back(model(ta, tb, tcin, tsub));
      #1;
    end
    in_valid = 1'b0;
    total++;
    if (!acc) begin
      bad++;
      $display("FAIL send_timeout: got=not accepted want=accepted");
    end
  endtask

  task automatic drain();
    out_ready = 1'b1;
    for (int n = 0; n < 100 && exp_q.size() > 0; n++) begin
      @(posedge clk); #1;
    end
    check("drain_empty", exp_q.size(), 0);
  endtask

  // Monitor: handshake rule, hold stability during stalls, ordered result compare.
  always @(negedge clk) begin
    if (rst) begin
      holding = 1'b0;
    end else begin
      if (!in_ready) saw_ir_low = 1;
      check("in_ready_rule", in_ready, (!out_valid || out_ready));
      if (holding) begin
        check("hold_valid", out_valid, 1);
        check("hold_data", {ovf, cout, sum}, held);
      end
      holding = out_valid && !out_ready;
      held = {ovf, cout, sum};
      if (out_valid && out_ready) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_output: got sum=%h cout=%0d ovf=%0d want=no output", sum, cout, ovf);
        end else begin
          logic [17:0] e;
          e = exp_q.pop_front();
          n_out++;
          if ({ovf, cout, sum} !== e) begin
            bad++;
            $display("FAIL result #%0d: got sum=%h cout=%0d ovf=%0d want sum=%h cout=%0d ovf=%0d",
                     n_out, sum, cout, ovf, e[15:0], e[16], e[17]);
          end else begin
            $display("result #%0d: sum=%h cout=%0d ovf=%0d ok", n_out, sum, cout, ovf);
          end
        end
      end
    end
  end

  initial begin
    int lat;
    bit seen;

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_out_valid", out_valid, 0);
    check("rst_sum", sum, 0);
    check("rst_cout", cout, 0);
    check("rst_ovf", ovf, 0);
    check("rst_in_ready", in_ready, 1);

    // Full carry propagation, with latency measured from the accept edge.
    send(16'hFFFF, 16'h0001, 1'b0, 1'b0);
    lat = 0;
    for (int n = 1; n <= 10 && lat == 0; n++) begin
      @(posedge clk); #1;
      if (out_valid) lat = n;
    end
    check("latency", lat, 4);
    drain();

    send(16'h7FFF, 16'h0000, 1'b1, 1'b0);
    send(16'h8000, 16'h0001, 1'b1, 1'b1);
    send(16'h0003, 16'h0005, 1'b0, 1'b1);
    drain();

    // Back-to-back adds with a 5-cycle output stall after the first result.
    saw_ir_low = 0;
    fork
      begin
        for (int i = 1; i <= 8; i++) send(16'(i), 16'(16'h0100 * i), 1'b0, 1'b0);
      end
      begin
        seen = 0;
        for (int n = 0; n < 50 && !seen; n++) begin
          @(posedge clk); #1;
          seen = out_valid;
        end
        check("stall_first_result", seen, 1);
        out_ready = 1'b0;
        repeat (5) begin @(posedge clk); #1; end
        out_ready = 1'b1;
      end
    join
    drain();
    check("stall_in_ready_low", saw_ir_low, 1);
    check("stall_count", n_out, 12);

    // Reset mid-flight: three ops in the pipe, reset collides with a new in_valid.
    send(16'h1111, 16'h2222, 1'b0, 1'b0);
    send(16'h3333, 16'h4444, 1'b0, 1'b0);
    send(16'h5555, 16'h6666, 1'b0, 1'b0);
    rst = 1'b1; in_valid = 1'b1; a = 16'h0101; b = 16'h0202;
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0;
    exp_q.delete();
    check("midrst_out_valid", out_valid, 0);
    for (int n = 0; n < 6; n++) begin
      @(posedge clk); #1;
      check("midrst_quiet", out_valid, 0);
    end
    send(16'h0F0F, 16'hF0F1, 1'b0, 1'b0);
    drain();

    // Random traffic with bubbles and random back-pressure.
    fork
      begin
        while (!rand_done) begin
          @(posedge clk); #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join_none
    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk); #1;
      end
      send(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
    end
    rand_done = 1;
    repeat (2) begin @(posedge clk); #1; end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got=still running want=finished");
    $fatal(1, "timeout");
  end
endmodule
